// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer_if
//  Description : Bundle of the fetch-control signals between the IF-stage
//                program counter sequencer and its surroundings (hazard unit,
//                EX-stage redirect, instruction memory, pipeline flush).
//                master : the sequencer (drives PC / request / flush outputs)
//                slave  : the pipeline side (drives stall / redirect / busy)
//  Signals     : STALL          hazard-unit hold request
//                BRANCH_TAKEN   EX-stage redirect strobe
//                BRANCH_TARGET  redirect address [31:0]
//                IMEM_BUSY      instruction memory not accepting the fetch
//                PC             current fetch address [31:0]
//                PC_PLUS4       PC + 4 (combinational) [31:0]
//                IMEM_REQ       fetch request
//                FLUSH          kill IF/ID and ID/EX contents
//                MISALIGN       one-cycle pulse for a misaligned redirect
//  Revision    : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if;
    logic        STALL;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic        IMEM_BUSY;
    logic [31:0] PC;
    logic [31:0] PC_PLUS4;
    logic        IMEM_REQ;
    logic        FLUSH;
    logic        MISALIGN;

    modport master (
        input  STALL, BRANCH_TAKEN, BRANCH_TARGET, IMEM_BUSY,
        output PC, PC_PLUS4, IMEM_REQ, FLUSH, MISALIGN
    );

    modport slave (
        output STALL, BRANCH_TAKEN, BRANCH_TARGET, IMEM_BUSY,
        input  PC, PC_PLUS4, IMEM_REQ, FLUSH, MISALIGN
    );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : IF-stage program counter for the RV32IM pipeline. Each cycle
//                the PC advances, holds (memory busy / hazard stall) or is
//                redirected by the EX stage. A redirect raises FLUSH for
//                FLUSH_CYCLES cycles to kill wrong-path instructions.
//  Parameters  : RESET_VECTOR  PC loaded on reset (word aligned)
//                FLUSH_CYCLES  cycles FLUSH stays high after a redirect (1..7)
//  Ports       : CLOCK  pipeline clock, rising edge
//                RESET  synchronous, active-low reset
//                bus    pc_sequencer_if.master (stall/redirect/busy in,
//                       PC/PC_PLUS4/IMEM_REQ/FLUSH/MISALIGN out)
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  wire logic      CLOCK,
    input  wire logic      RESET,
    pc_sequencer_if.master bus
);

    localparam logic [1:0] ST_FETCH    = 2'd0;
    localparam logic [1:0] ST_WAIT_MEM = 2'd1;
    localparam logic [1:0] ST_FLUSH    = 2'd2;

    localparam logic [2:0] c_FLUSH_INIT = 3'(FLUSH_CYCLES);

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [2:0]  r_cnt;
    logic        r_flush;
    logic        r_misalign;

    logic [1:0]  w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [2:0]  w_cnt_nxt;
    logic        w_flush_nxt;
    logic        w_misalign_nxt;
    logic        w_redirect;
    logic [31:0] w_pc_plus4;

    assign w_pc_plus4 = r_pc + 32'd4;

    // A redirect arriving during the flush window comes from an instruction
    // that is itself being killed, so it is ignored.
    assign w_redirect = bus.BRANCH_TAKEN && (r_state != ST_FLUSH);

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_cnt_nxt      = r_cnt;
        w_flush_nxt    = r_flush;
        w_misalign_nxt = 1'b0;

        if (w_redirect) begin
            // Redirect beats busy and stall; the outstanding fetch is dropped.
            w_pc_nxt       = {bus.BRANCH_TARGET[31:2], 2'b00};
            w_misalign_nxt = |bus.BRANCH_TARGET[1:0];
            w_cnt_nxt      = c_FLUSH_INIT;
            w_flush_nxt    = 1'b1;
            w_state_nxt    = ST_FLUSH;
        end else begin
            // PC movement is the same in every state, including the flush
            // window, so the correct path is fetched while the pipe drains.
            if (!bus.IMEM_BUSY && !bus.STALL) begin
                w_pc_nxt = w_pc_plus4;
            end

            case (r_state)
                ST_FETCH: begin
                    if (bus.IMEM_BUSY) begin
                        w_state_nxt = ST_WAIT_MEM;
                    end
                end
                ST_WAIT_MEM: begin
                    if (!bus.IMEM_BUSY) begin
                        w_state_nxt = ST_FETCH;
                    end
                end
                ST_FLUSH: begin
                    // Counter runs regardless of stall/busy; the flush ends
                    // on the cycle it reaches zero.
                    w_cnt_nxt = r_cnt - 3'd1;
                    if (r_cnt <= 3'd1) begin
                        w_cnt_nxt   = 3'd0;
                        w_flush_nxt = 1'b0;
                        w_state_nxt = bus.IMEM_BUSY ? ST_WAIT_MEM : ST_FETCH;
                    end else begin
                        w_flush_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_FETCH;
                    w_flush_nxt = 1'b0;
                    w_cnt_nxt   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            r_state    <= ST_FETCH;
            r_pc       <= RESET_VECTOR;
            r_cnt      <= 3'd0;
            r_flush    <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_cnt      <= w_cnt_nxt;
            r_flush    <= w_flush_nxt;
            r_misalign <= w_misalign_nxt;
        end
    end

    assign bus.PC       = r_pc;
    assign bus.PC_PLUS4 = w_pc_plus4;
    // Fetch is requested in every state once out of reset.
    assign bus.IMEM_REQ = RESET;
    assign bus.FLUSH    = r_flush;
    assign bus.MISALIGN = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Self-checking bench for pc_sequencer. Directed scenarios
//                (reset, stall/busy, redirect, priority, misalign/wrap,
//                reset mid-flush) followed by a randomized run, all checked
//                against a cycle-level reference model of the PC rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam int          FC = 2;

    logic CLOCK;
    logic RESET;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_VECTOR (RV),
        .FLUSH_CYCLES (FC)
    ) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus.master)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // Reference model: PC value, flush cycles still to run, misalign pulse.
    logic [31:0] m_pc;
    int          m_left;
    logic        m_mis;

    int n_cmp;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, check request, step model across the edge,
    // then check the registered outputs 1 time unit after the edge.
    task automatic cyc(input logic rst, input logic st, input logic bt,
                       input logic [31:0] tgt, input logic busy);
        RESET             = rst;
        bus.STALL         = st;
        bus.BRANCH_TAKEN  = bt;
        bus.BRANCH_TARGET = tgt;
        bus.IMEM_BUSY     = busy;
        #1;
        check("imem_req", {31'd0, bus.IMEM_REQ}, {31'd0, rst});
        @(posedge CLOCK);
        if (!rst) begin
            m_pc   = RV;
            m_left = 0;
            m_mis  = 1'b0;
        end else if (bt && m_left == 0) begin
            m_pc   = tgt & 32'hFFFF_FFFC;
            m_mis  = (tgt % 4) != 0;
            m_left = FC;
        end else begin
            m_mis = 1'b0;
            if (m_left > 0) m_left--;
            if (!busy && !st) m_pc = m_pc + 32'd4;
        end
        #1;
        check("pc",       bus.PC,       m_pc);
        check("pc_plus4", bus.PC_PLUS4, m_pc + 32'd4);
        check("flush",    {31'd0, bus.FLUSH},    {31'd0, (m_left > 0)});
        check("misalign", {31'd0, bus.MISALIGN}, {31'd0, m_mis});
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        m_pc   = RV;
        m_left = 0;
        m_mis  = 1'b0;
        RESET  = 1'b0;
        bus.STALL = 1'b0;
        bus.BRANCH_TAKEN = 1'b0;
        bus.BRANCH_TARGET = 32'h0;
        bus.IMEM_BUSY = 1'b0;

        // T1: reset then free-run
        cyc(0, 0, 0, 32'h0, 0);
        cyc(0, 0, 0, 32'h0, 0);
        check("reset_pc", bus.PC, 32'h0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 32'h0, 0);
        check("t1_pc16", bus.PC, 32'h10);

        // T2: stall 2, busy 3, release
        cyc(1, 1, 0, 32'h0, 0);
        cyc(1, 1, 0, 32'h0, 0);
        check("t2_stall_hold", bus.PC, 32'h10);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 32'h0, 1);
        check("t2_busy_hold", bus.PC, 32'h10);
        cyc(1, 0, 0, 32'h0, 0);
        check("t2_release", bus.PC, 32'h14);

        // T3: redirect from 0x20, redirect in flush window ignored
        for (int i = 0; i < 8 && m_pc != 32'h20; i++) cyc(1, 0, 0, 32'h0, 0);
        cyc(1, 0, 1, 32'h100, 0);
        check("t3_target", bus.PC, 32'h100);
        check("t3_flush", {31'd0, bus.FLUSH}, 32'd1);
        cyc(1, 0, 1, 32'h300, 0);
        check("t3_ignored", bus.PC, 32'h104);
        cyc(1, 0, 0, 32'h0, 0);
        cyc(1, 0, 0, 32'h0, 0);

        // T4: redirect beats stall and busy; busy persists through flush
        cyc(1, 1, 1, 32'h40, 1);
        check("t4_pc", bus.PC, 32'h40);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 32'h0, 1);
        check("t4_hold", bus.PC, 32'h40);
        check("t4_flush_clear", {31'd0, bus.FLUSH}, 32'd0);
        cyc(1, 0, 0, 32'h0, 0);

        // T5: misaligned target, then wrap-around
        cyc(1, 0, 1, 32'h203, 0);
        check("t5_align", bus.PC, 32'h200);
        check("t5_mis", {31'd0, bus.MISALIGN}, 32'd1);
        cyc(1, 0, 0, 32'h0, 0);
        cyc(1, 0, 0, 32'h0, 0);
        cyc(1, 0, 1, 32'hFFFF_FFFC, 0);
        cyc(1, 0, 0, 32'h0, 0);
        check("t5_wrap", bus.PC, 32'h0);
        check("t5_wrap_p4", bus.PC_PLUS4, 32'h4);
        cyc(1, 0, 0, 32'h0, 0);

        // T6: reset on first flush cycle
        cyc(1, 0, 1, 32'h501, 0);
        cyc(0, 0, 1, 32'h700, 1);
        check("t6_pc", bus.PC, RV);
        cyc(1, 0, 0, 32'h0, 0);
        check("t6_run", bus.PC, RV + 32'd4);

        // Randomized run
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 49) != 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 7) == 0),
                $urandom(),
                ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
